// File: rtl/name_pkg.sv
// Shared constants for the name sequence checker: the expected character table,
// the restart character and the one-hot ring encodings used on restart.
package name_pkg;

  localparam int NAME_LEN = 18;
  localparam int CHAR_W   = 7;
  localparam int IDX_W    = 5;

  // Entry 0 is the leftmost element, so NAME_TABLE[i] is character i of "Ramandeep Chumber ".
  localparam logic [0:NAME_LEN-1][CHAR_W-1:0] NAME_TABLE = {
    7'h52, 7'h61, 7'h6D, 7'h61, 7'h6E, 7'h64,
    7'h65, 7'h65, 7'h70, 7'h20, 7'h43, 7'h68,
    7'h75, 7'h6D, 7'h62, 7'h65, 7'h72, 7'h20
  };

  localparam logic [CHAR_W-1:0] CHAR_R = 7'h52;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NAME_LEN - 1);

  function automatic logic [0:NAME_LEN-1] onehot_pos(input logic [IDX_W-1:0] i);
    logic [0:NAME_LEN-1] v;
    v = '0;
    for (int k = 0; k < NAME_LEN; k++) begin
      if (i == IDX_W'(k)) v[k] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/name_rom.sv
// Combinational lookup of the character expected at a given sequence position.
// Unused addresses return zero.
module name_rom
  import name_pkg::*;
(
  input  logic [IDX_W-1:0]  idx,
  output logic [CHAR_W-1:0] char_out
);

  always_comb begin
    char_out = '0;
    for (int i = 0; i < NAME_LEN; i++) begin
      if (idx == IDX_W'(i)) char_out = NAME_TABLE[i];
    end
  end

endmodule

// File: rtl/name_decoder.sv
// Checks an incoming character stream against the fixed name sequence, tracking the
// expected position as a one-hot ring and counting complete names.
module name_decoder
  import name_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [CHAR_W-1:0]   char_in,
  input  logic                char_valid,
  output logic [0:NAME_LEN-1] pos,
  output logic [IDX_W-1:0]    idx,
  output logic                match,
  output logic                err,
  output logic [CNT_W-1:0]    name_count
);

  logic [CHAR_W-1:0]   exp_char;
  logic [0:NAME_LEN-1] pos_next;
  logic [IDX_W-1:0]    idx_next;
  logic                match_next;
  logic                err_next;
  logic [CNT_W-1:0]    count_next;

  name_rom u_rom (
    .idx      (idx),
    .char_out (exp_char)
  );

  always_comb begin
    pos_next   = pos;
    idx_next   = idx;
    match_next = 1'b0;
    err_next   = 1'b0;
    count_next = name_count;
    if (char_valid) begin
      if (char_in == exp_char) begin
        if (idx == LAST_IDX) begin
          pos_next   = onehot_pos('0);
          idx_next   = '0;
          match_next = 1'b1;
          if (name_count != {CNT_W{1'b1}}) count_next = name_count + 1'b1;
        end else begin
          // Ring rotation: the token moves from position i to i+1.
          pos_next = {pos[NAME_LEN-1], pos[0:NAME_LEN-2]};
          idx_next = idx + 1'b1;
        end
      end else begin
        // Naive restart: only a fresh 'R' is treated as the start of a new name.
        err_next = 1'b1;
        if (char_in == CHAR_R) begin
          pos_next = onehot_pos(IDX_W'(1));
          idx_next = IDX_W'(1);
        end else begin
          pos_next = onehot_pos('0);
          idx_next = '0;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pos        <= onehot_pos('0);
      idx        <= '0;
      match      <= 1'b0;
      err        <= 1'b0;
      name_count <= '0;
    end else begin
      pos        <= pos_next;
      idx        <= idx_next;
      match      <= match_next;
      err        <= err_next;
      name_count <= count_next;
    end
  end

endmodule

// File: tb/tb_name_decoder.sv
// Scoreboard bench for name_decoder: stimulus pushes expected responses, a monitor
// pops and compares one entry per clock.
module tb_name_decoder;

  localparam int CNT_W = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [6:0]  char_in = '0;
  logic        char_valid = 1'b0;
  logic [0:17] pos;
  logic [4:0]  idx;
  logic        match;
  logic        err;
  logic [CNT_W-1:0] name_count;

  typedef struct {
    logic [0:17]      pos;
    logic [4:0]       idx;
    logic             match;
    logic             err;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int m_idx = 0;
  int m_cnt = 0;
  int match_seen = 0;
  string name_str = "Ramandeep Chumber ";

  name_decoder #(.CNT_W(CNT_W)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .char_in    (char_in),
    .char_valid (char_valid),
    .pos        (pos),
    .idx        (idx),
    .match      (match),
    .err        (err),
    .name_count (name_count)
  );

  always #5 CLK = ~CLK;

  function automatic logic [0:17] exp_pos(input int i);
    logic [0:17] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (match) match_seen++;
      if (pos !== e.pos || idx !== e.idx || match !== e.match || err !== e.err || name_count !== e.cnt) begin
        errors++;
        $display("FAIL step: got pos=%h idx=%0d match=%b err=%b cnt=%0d, want pos=%h idx=%0d match=%b err=%b cnt=%0d",
                 pos, idx, match, err, name_count, e.pos, e.idx, e.match, e.err, e.cnt);
      end else begin
        $display("ok   step: pos=%h idx=%0d match=%b err=%b cnt=%0d", pos, idx, match, err, name_count);
      end
    end
  end

  task automatic send(input logic v, input logic [6:0] c);
    exp_t e;
    @(negedge CLK);
    char_valid = v;
    char_in    = c;
    e.match = 1'b0;
    e.err   = 1'b0;
    if (v) begin
      if (c == 7'(name_str[m_idx])) begin
        if (m_idx == 17) begin
          m_idx = 0;
          e.match = 1'b1;
          if (m_cnt != CNT_MAX) m_cnt++;
        end else begin
          m_idx++;
        end
      end else begin
        e.err = 1'b1;
        m_idx = (c == 7'h52) ? 1 : 0;
      end
    end
    e.idx = 5'(m_idx);
    e.pos = exp_pos(m_idx);
    e.cnt = CNT_W'(m_cnt);
    q.push_back(e);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(1'b1, 7'(s[i]));
  endtask

  // Hand-computed spot check after one idle cycle has been scored.
  task automatic check_now(input string nm, input int want_idx, input int want_cnt);
    send(1'b0, 7'h00);
    @(negedge CLK);
    checks++;
    if (idx !== 5'(want_idx) || name_count !== CNT_W'(want_cnt) || pos !== exp_pos(want_idx)) begin
      errors++;
      $display("FAIL %s: got idx=%0d pos=%h cnt=%0d, want idx=%0d cnt=%0d", nm, idx, pos, name_count, want_idx, want_cnt);
    end else begin
      $display("ok   %s: idx=%0d cnt=%0d", nm, idx, name_count);
    end
  endtask

  task automatic check_reset(input string nm);
    checks++;
    if (pos !== 18'h20000 || idx !== 5'd0 || match !== 1'b0 || err !== 1'b0 || name_count !== '0) begin
      errors++;
      $display("FAIL %s: got pos=%h idx=%0d match=%b err=%b cnt=%0d, want reset values", nm, pos, idx, match, err, name_count);
    end else begin
      $display("ok   %s: reset values", nm);
    end
  endtask

  task automatic do_reset(input string nm);
    @(negedge CLK);
    char_valid = 1'b0;
    #2 RST = 1'b1;
    #1 check_reset(nm);
    m_idx = 0;
    m_cnt = 0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #1 check_reset("reset_hold");
    @(negedge CLK);
    RST = 1'b0;
    repeat (5) send(1'b0, 7'h00);

    // Clean name
    send_str(name_str);
    check_now("clean_name", 0, 1);

    // Non-'R' mismatch then a full name
    do_reset("reset_t3");
    send_str("Ram");
    send(1'b1, 7'h78);
    check_now("mismatch_x", 0, 0);
    send_str(name_str);
    check_now("after_x_name", 0, 1);

    // 'R' restart mismatch
    do_reset("reset_t4");
    send_str("Ra");
    send(1'b1, 7'h52);
    check_now("restart_r", 1, 0);
    send_str("amandeep Chumber ");
    check_now("after_r_name", 0, 1);

    // Gapped input, then asynchronous reset between edges
    do_reset("reset_t5");
    for (int i = 0; i < 10; i++) begin
      send(1'b1, 7'(name_str[i]));
      repeat (3) send(1'b0, 7'h00);
    end
    check_now("gapped_10", 10, 0);
    do_reset("async_mid");
    send_str(name_str);
    check_now("after_async", 0, 1);

    // Saturation
    do_reset("reset_t6");
    match_seen = 0;
    for (int n = 1; n <= 5; n++) begin
      send_str(name_str);
      check_now($sformatf("sat_name%0d", n), 0, (n > CNT_MAX) ? CNT_MAX : n);
    end
    checks++;
    if (match_seen != 5) begin
      errors++;
      $display("FAIL match_pulses: got %0d, want 5", match_seen);
    end else begin
      $display("ok   match_pulses: %0d", match_seen);
    end

    repeat (2) @(negedge CLK);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
